// File: rtl/bin2ascii_seq.sv
// Sequential binary-to-ASCII decimal formatter: one double-dabble step per clock,
// followed by one formatting cycle that applies blanking and overflow marking.
module bin2ascii_seq #(
  parameter int P_WIDTH  = 16,
  parameter int P_DIGITS = 5,
  parameter int P_BLANK  = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [P_WIDTH-1:0]      i_data_in,
  output logic [8*P_DIGITS-1:0]   o_digits,
  output logic                    o_valid,
  output logic                    o_busy,
  output logic                    o_ovf
);

  localparam int L_BCD = 4 * P_DIGITS;
  localparam int L_CNT = $clog2(P_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FORMAT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [P_WIDTH-1:0]      bin_q, bin_d;
  logic [L_BCD-1:0]        bcd_q, bcd_d, bcd_adj_s;
  logic [L_CNT-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic [8*P_DIGITS-1:0]   digits_q, digits_d, fmt_s;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    ovf_out_q, ovf_out_d;

  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    logic [7:0] chr;
    case (nib)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
      4'd5, 4'd6, 4'd7, 4'd8, 4'd9: chr = {4'h3, nib};
      default:                      chr = 8'h3F;
    endcase
    return chr;
  endfunction

  // Add-3 correction on every nibble that would reach 10 or more after the shift
  always_comb begin
    bcd_adj_s = '0;
    for (int i = 0; i < P_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj_s[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj_s[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end
  end

  // Character mapping: leading-zero blanking from the top down, units never blanked
  always_comb begin
    logic lead_s;
    fmt_s  = '0;
    lead_s = (P_BLANK != 0);
    for (int i = P_DIGITS - 1; i >= 1; i--) begin
      if (lead_s && (bcd_q[4*i +: 4] == 4'd0)) begin
        fmt_s[8*i +: 8] = 8'h20;
      end else begin
        lead_s          = 1'b0;
        fmt_s[8*i +: 8] = nib2ascii(bcd_q[4*i +: 4]);
      end
    end
    fmt_s[7:0] = nib2ascii(bcd_q[3:0]);
    if (ovf_q) begin
      fmt_s = {P_DIGITS{8'h3F}};
    end else begin
      fmt_s = fmt_s;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    digits_d  = digits_q;
    ovf_out_d = ovf_out_q;
    valid_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          bin_d   = i_data_in;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = L_CNT'(P_WIDTH);
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // a bit carried out of the top nibble means the value needs more digits
        bcd_d = {bcd_adj_s[L_BCD-2:0], bin_q[P_WIDTH-1]};
        bin_d = {bin_q[P_WIDTH-2:0], 1'b0};
        ovf_d = ovf_q | bcd_adj_s[L_BCD-1];
        cnt_d = cnt_q - L_CNT'(1);
        if (cnt_q == L_CNT'(1)) begin
          state_d = ST_FORMAT;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_FORMAT: begin
        digits_d  = fmt_s;
        ovf_out_d = ovf_q;
        valid_d   = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      digits_q  <= {P_DIGITS{8'h30}};
      ovf_out_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      digits_q  <= digits_d;
      ovf_out_q <= ovf_out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign o_digits = digits_q;
  assign o_valid  = valid_q;
  assign o_busy   = busy_q;
  assign o_ovf    = ovf_out_q;

endmodule

// File: tb/tb_bin2ascii_seq.sv
// Randomised bench for bin2ascii_seq: four parameter variants checked against a
// divide/modulo decimal reference model.
module tb_bin2ascii_seq;

  logic        clk;
  logic        rst_n;
  logic        start16, start8;
  logic [15:0] din16;
  logic [7:0]  din8;

  logic [39:0] dig_a, dig_b;
  logic [31:0] dig_c;
  logic [23:0] dig_w;
  logic        val_a, busy_a, ovf_a;
  logic        val_b, busy_b, ovf_b;
  logic        val_c, busy_c, ovf_c;
  logic        val_w, busy_w, ovf_w;

  int n_checks = 0;
  int n_errors = 0;

  bin2ascii_seq #(.P_WIDTH(16), .P_DIGITS(5), .P_BLANK(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start16), .i_data_in(din16),
    .o_digits(dig_a), .o_valid(val_a), .o_busy(busy_a), .o_ovf(ovf_a));

  bin2ascii_seq #(.P_WIDTH(16), .P_DIGITS(5), .P_BLANK(0)) u_nb (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start16), .i_data_in(din16),
    .o_digits(dig_b), .o_valid(val_b), .o_busy(busy_b), .o_ovf(ovf_b));

  bin2ascii_seq #(.P_WIDTH(16), .P_DIGITS(4), .P_BLANK(1)) u_d4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start16), .i_data_in(din16),
    .o_digits(dig_c), .o_valid(val_c), .o_busy(busy_c), .o_ovf(ovf_c));

  bin2ascii_seq #(.P_WIDTH(8), .P_DIGITS(3), .P_BLANK(1)) u_w8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_data_in(din8),
    .o_digits(dig_w), .o_valid(val_w), .o_busy(busy_w), .o_ovf(ovf_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit ref_ovf(input longint v, input int nd);
    longint lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    return (v >= lim);
  endfunction

  // Decimal string by division: digit i is blank when the value is below 10^i
  function automatic logic [63:0] ref_fmt(input longint v, input int nd, input bit blank);
    logic [63:0] r = '0;
    longint p = 1;
    if (ref_ovf(v, nd)) begin
      for (int i = 0; i < nd; i++) r[8*i +: 8] = 8'h3F;
    end else begin
      for (int i = 0; i < nd; i++) begin
        if (blank && i > 0 && v < p) r[8*i +: 8] = 8'h20;
        else r[8*i +: 8] = 8'h30 + 8'((v / p) % 10);
        p = p * 10;
      end
    end
    return r;
  endfunction

  task automatic check_16(input string tag, input logic [15:0] v);
    check({tag, "_dig5b"}, dig_a, ref_fmt(v, 5, 1'b1));
    check({tag, "_ovf5"},  ovf_a, ref_ovf(v, 5));
    check({tag, "_dig5n"}, dig_b, ref_fmt(v, 5, 1'b0));
    check({tag, "_dig4"},  dig_c, ref_fmt(v, 4, 1'b1));
    check({tag, "_ovf4"},  ovf_c, ref_ovf(v, 4));
  endtask

  task automatic run_conv(input logic [15:0] v);
    int n = 0;
    int busy_n = 0;
    @(negedge clk); start16 = 1'b1; din16 = v;
    @(negedge clk); start16 = 1'b0; din16 = 16'($urandom);
    while (!val_a && n < 40) begin
      if (busy_a) busy_n++;
      @(negedge clk); n++;
    end
    check("latency", n, 17);
    check("busy_cycles", busy_n, 17);
    check("busy_at_valid", busy_a, 1'b0);
    check("valid_sync", {val_b, val_c}, 2'b11);
    check_16("conv", v);
    @(negedge clk);
    check("valid_pulse", val_a, 1'b0);
    check("hold", dig_a, ref_fmt(v, 5, 1'b1));
  endtask

  task automatic run_w8(input logic [7:0] v);
    int n = 0;
    @(negedge clk); start8 = 1'b1; din8 = v;
    @(negedge clk); start8 = 1'b0; din8 = 8'($urandom);
    while (!val_w && n < 30) begin
      @(negedge clk); n++;
    end
    check("w8_latency", n, 9);
    check("w8_dig", dig_w, ref_fmt(v, 3, 1'b1));
    check("w8_ovf", ovf_w, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [15:0] q[$];
    logic [15:0] v;
    int nv;
    rst_n = 1'b0; start16 = 1'b0; start8 = 1'b0; din16 = '0; din8 = '0;
    repeat (2) @(negedge clk);
    check("rst_dig", dig_a, {5{8'h30}});
    check("rst_flags", {val_a, busy_a, ovf_a}, 3'b000);
    check("rst_dig_w8", dig_w, {3{8'h30}});
    rst_n = 1'b1;

    // directed values, then random mix biased toward the 4-digit boundary
    run_conv(16'd65535);
    run_conv(16'd0);
    run_conv(16'd42);
    run_conv(16'd10000);
    run_conv(16'd12345);
    run_conv(16'd9999);
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0:       v = 16'd9999;
        1:       v = 16'd10000;
        2:       v = 16'($urandom_range(0, 99));
        default: v = 16'($urandom);
      endcase
      run_conv(v);
    end

    // start while busy is ignored
    nv = 0;
    @(negedge clk); start16 = 1'b1; din16 = 16'd100;
    @(negedge clk); start16 = 1'b0; din16 = 16'd7;
    repeat (4) @(negedge clk);
    start16 = 1'b1; din16 = 16'd200;
    @(negedge clk); start16 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (val_a) begin
        nv++;
        check("busy_ignore_dig", dig_a, ref_fmt(100, 5, 1'b1));
      end
      @(negedge clk);
    end
    check("busy_ignore_count", nv, 1);
    run_conv(16'd200);

    // back-to-back with start held high; captures at edges 0, 18, 36, 54
    nv = 0;
    @(negedge clk); start16 = 1'b1;
    for (int c = 0; c < 72; c++) begin
      din16 = 16'($urandom);
      if (c % 18 == 0) q.push_back(din16);
      @(negedge clk);
      if (val_a) begin
        nv++;
        check("b2b_phase", c % 18, 17);
        if (q.size() > 0) check_16("b2b", q.pop_front());
        else check("b2b_extra", 1'b1, 1'b0);
      end
    end
    start16 = 1'b0;
    check("b2b_count", nv, 4);
    repeat (3) @(negedge clk);

    // reset mid-conversion
    nv = 0;
    @(negedge clk); start16 = 1'b1; din16 = 16'd54321;
    @(negedge clk); start16 = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_dig", dig_a, {5{8'h30}});
    check("midrst_flags", {val_a, busy_a, ovf_a}, 3'b000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (val_a) nv++;
    end
    check("midrst_no_valid", nv, 0);
    check("midrst_hold", dig_a, {5{8'h30}});
    run_conv(16'($urandom));

    // narrow variant
    run_w8(8'd255);
    run_w8(8'd0);
    for (int i = 0; i < 4; i++) run_w8(8'($urandom));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
